// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with a registered result. Shift-add multiply returns a 2*WIDTH product.
// Latency: 1 cycle for logic/add/sub/shift/illegal ops; WIDTH cycles for MUL.
// Backpressure: the result is held stable until out_ready; in_ready is low while MUL iterates or the result is held.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid/in_ready            operation handshake (in_opcode, in_a, in_b, in_tag)
//   out_valid/out_ready          result handshake (out_result, out_result_hi, flags, out_tag)

package seq_alu_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    AND = 4'd3,
    OR  = 4'd4,
    XOR = 4'd5,
    SHL = 4'd6,
    SHR = 4'd7
  } opcode_t;
endpackage

module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  opcode_t            in_opcode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [WIDTH-1:0]   out_result_hi,
  output logic               out_zero,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  localparam int               CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  // WIDTH always fits in WIDTH bits, so the shift limit is representable.
  localparam logic [WIDTH-1:0] SH_LIM   = WIDTH'(WIDTH);

  state_t             state, state_nxt;
  logic               accept;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     psum;

  logic [WIDTH-1:0]   r_res;
  logic               r_zero, r_carry, r_ovf, r_ill;

  // Control: in_ready depends only on state and out_ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_opcode == MUL) ? BUSY : HOLD;
      end
      BUSY: begin
        if (cnt == CNT_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_nxt = (in_opcode == MUL) ? BUSY : HOLD;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // One shift-add step: the upper half accumulates the multiplicand when the
  // current multiplier bit (prod[0]) is set, then the whole register shifts
  // right. The multiplier is consumed from the low half as product bits fill in.
  always_comb begin
    psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {psum, prod[WIDTH-1:1]};
  end

  // Single-cycle operations, evaluated on the live inputs for the accept edge.
  always_comb begin
    r_res   = '0;
    r_carry = 1'b0;
    r_ovf   = 1'b0;
    r_ill   = 1'b0;
    case (in_opcode)
      ADD: begin
        {r_carry, r_res} = {1'b0, in_a} + {1'b0, in_b};
        r_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (r_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      SUB: begin
        r_res   = in_a - in_b;
        r_carry = (in_a < in_b);
        r_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (r_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      MUL: r_res = '0;  // handled by the iterative path
      AND: r_res = in_a & in_b;
      OR:  r_res = in_a | in_b;
      XOR: r_res = in_a ^ in_b;
      SHL: r_res = (in_b >= SH_LIM) ? '0 : (in_a << in_b);
      SHR: r_res = (in_b >= SH_LIM) ? '0 : (in_a >> in_b);
      default: r_ill = 1'b1;
    endcase
    r_zero = (r_res == '0);
  end

  // Result registers only change on an accept or on MUL completion, so they
  // stay stable while a held result waits for out_ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt           <= '0;
      mcand         <= '0;
      prod          <= '0;
      out_result    <= '0;
      out_result_hi <= '0;
      out_zero      <= 1'b0;
      out_carry     <= 1'b0;
      out_ovf       <= 1'b0;
      out_illegal   <= 1'b0;
      out_tag       <= '0;
    end else if (accept) begin
      out_tag <= in_tag;
      if (in_opcode == MUL) begin
        mcand <= in_a;
        prod  <= {{WIDTH{1'b0}}, in_b};
        cnt   <= '0;
      end else begin
        out_result    <= r_res;
        out_result_hi <= '0;
        out_zero      <= r_zero;
        out_carry     <= r_carry;
        out_ovf       <= r_ovf;
        out_illegal   <= r_ill;
      end
    end else if (state == BUSY) begin
      if (cnt == CNT_LAST) begin
        out_result    <= prod_step[WIDTH-1:0];
        out_result_hi <= prod_step[2*WIDTH-1:WIDTH];
        out_zero      <= (prod_step == '0);
        out_carry     <= |prod_step[2*WIDTH-1:WIDTH];
        out_ovf       <= 1'b0;
        out_illegal   <= 1'b0;
      end else begin
        prod <= prod_step;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule
